dpram_portb_arbiter: RTL and testbench

Two-requester arbiter that shares port B of the ZPU dual-port block RAM between the ZPU core data path (requester 0) and a second master such as a program loader, DMA or debug agent (requester 1). Port A stays owned by the core. The block grants at most one access per cycle and drives the RAM port-B signals. It returns read data and write acknowledges with a fixed one-cycle latency, and uses round-robin arbitration with bounded burst locking.

---
 rtl/dpram_portb_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_dpram_portb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_portb_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_portb_arbiter
//
// Shares port B of the ZPU dual-port block RAM between two requesters:
//   requester 0 : ZPU core data path
//   requester 1 : secondary master (program loader, DMA, debug agent)
// Port A of the RAM stays owned by the core and is not seen here.
//
// At most one access is granted per cycle. Arbitration is round-robin with an
// optional lock that lets the current owner keep the port for up to MAX_BURST
// consecutive grants. Responses come back exactly one cycle after the grant,
// tagged by rsp0_valid / rsp1_valid on a shared data bus.
//
// Ports
//   clk, areset_n              clock (rising edge), asynchronous active-low reset
//   reqN_valid/we/addr/wdata   access request from requester N (held until gntN)
//   reqN_lock                  ask to keep ownership for the following cycle
//   gntN                       combinational grant for the current cycle
//   rspN_valid                 response for the access granted last cycle
//   rsp_rdata                  shared response data (equal to memBRead)
//   memBWriteEnable/Addr/Write RAM port B controls
//   memBRead                   registered read data from RAM port B
// -----------------------------------------------------------------------------
module dpram_portb_arbiter #(
   parameter int wordSize       = 32,
   parameter int maxAddrBitBRAM = 15,
   parameter int minAddrBit     = 2,
   parameter int MAX_BURST      = 8,
   localparam int AW            = maxAddrBitBRAM - minAddrBit + 1
) (
   input  logic                clk,
   input  logic                areset_n,

   input  logic                req0_valid,
   input  logic                req0_we,
   input  logic [AW-1:0]       req0_addr,
   input  logic [wordSize-1:0] req0_wdata,
   input  logic                req0_lock,

   input  logic                req1_valid,
   input  logic                req1_we,
   input  logic [AW-1:0]       req1_addr,
   input  logic [wordSize-1:0] req1_wdata,
   input  logic                req1_lock,

   output logic                gnt0,
   output logic                gnt1,
   output logic                rsp0_valid,
   output logic                rsp1_valid,
   output logic [wordSize-1:0] rsp_rdata,

   output logic                memBWriteEnable,
   output logic [AW-1:0]       memBAddr,
   output logic [wordSize-1:0] memBWrite,
   input  logic [wordSize-1:0] memBRead
);

   // Owner encoding shared by the lock owner and the response selector.
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_REQ0 = 2'b01,
      OWN_REQ1 = 2'b10
   } owner_e;

   localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

   // ------------------------------------------------------------------------
   // Requester signals gathered into indexable form
   // ------------------------------------------------------------------------
   logic [1:0]          reqValid;
   logic [1:0]          reqWe;
   logic [1:0]          reqLock;
   logic [AW-1:0]       reqAddr  [2];
   logic [wordSize-1:0] reqWdata [2];

   assign reqValid    = {req1_valid, req0_valid};
   assign reqWe       = {req1_we,    req0_we};
   assign reqLock     = {req1_lock,  req0_lock};
   assign reqAddr[0]  = req0_addr;
   assign reqAddr[1]  = req1_addr;
   assign reqWdata[0] = req0_wdata;
   assign reqWdata[1] = req1_wdata;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic       lastGntReg,   lastGntNext;
   owner_e     lockOwnerReg, lockOwnerNext;
   logic [7:0] burstCntReg,  burstCntNext;
   owner_e     rspSelReg,    rspSelNext;

   // ------------------------------------------------------------------------
   // Lock hold: the locked owner keeps the port only while it is still
   // requesting and its burst budget is not exhausted. Dropping valid releases
   // the lock in the same cycle, so the other side can be served at once.
   // ------------------------------------------------------------------------
   logic       burstBelowMax;
   logic [1:0] lockHold;

   assign burstBelowMax = (burstCntReg < MAX_BURST_C);

   for (genvar gi = 0; gi < 2; gi++) begin : g_lockHold
      localparam owner_e OWN_GI = (gi == 0) ? OWN_REQ0 : OWN_REQ1;
      assign lockHold[gi] = (lockOwnerReg == OWN_GI) && reqValid[gi] && burstBelowMax;
   end

   // ------------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------------
   logic grantAny;     // some requester wins this cycle (before reset gating)
   logic grantIdx;     // which one
   logic grantLive;    // grant actually issued (suppressed while in reset)

   always_comb begin
      grantAny = 1'b0;
      grantIdx = 1'b0;
      if (lockHold[0]) begin
         grantAny = 1'b1;
         grantIdx = 1'b0;
      end else if (lockHold[1]) begin
         grantAny = 1'b1;
         grantIdx = 1'b1;
      end else begin
         unique case (reqValid)
            2'b01: begin
               grantAny = 1'b1;
               grantIdx = 1'b0;
            end
            2'b10: begin
               grantAny = 1'b1;
               grantIdx = 1'b1;
            end
            2'b11: begin
               // Contention: favour whoever was not served last.
               grantAny = 1'b1;
               grantIdx = ~lastGntReg;
            end
            default: begin
               grantAny = 1'b0;
               grantIdx = 1'b0;
            end
         endcase
      end
   end

   // Grants must stay low for the whole reset assertion, not only after the
   // next edge, so the async reset level gates them combinationally.
   assign grantLive = grantAny & areset_n;

   assign gnt0 = grantLive & ~grantIdx;
   assign gnt1 = grantLive &  grantIdx;

   // ------------------------------------------------------------------------
   // Port B mux. With no grant the address/data follow requester 0 so the
   // idle bus is stable and deterministic; the write enable stays low.
   // ------------------------------------------------------------------------
   logic muxSel;

   assign muxSel          = grantLive & grantIdx;
   assign memBAddr        = reqAddr[muxSel];
   assign memBWrite       = reqWdata[muxSel];
   assign memBWriteEnable = grantLive & reqWe[grantIdx];

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   owner_e grantOwner;

   always_comb begin
      grantOwner    = grantIdx ? OWN_REQ1 : OWN_REQ0;
      lastGntNext   = lastGntReg;
      burstCntNext  = 8'd0;
      lockOwnerNext = OWN_NONE;
      rspSelNext    = OWN_NONE;

      if (grantLive) begin
         lastGntNext = grantIdx;
         // rspSelReg names the grantee of the previous cycle; a run of grants
         // to the same requester counts up and saturates at MAX_BURST.
         if (rspSelReg == grantOwner) begin
            if (burstCntReg >= MAX_BURST_C) begin
               burstCntNext = MAX_BURST_C;
            end else begin
               burstCntNext = burstCntReg + 8'd1;
            end
         end else begin
            burstCntNext = 8'd1;
         end
         lockOwnerNext = reqLock[grantIdx] ? grantOwner : OWN_NONE;
         rspSelNext    = grantOwner;
      end
   end

   // ------------------------------------------------------------------------
   // State registers. lastGnt resets to 1 so requester 0 wins first contention.
   // Clearing rspSel on reset drops any response still in flight.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         lastGntReg   <= 1'b1;
         lockOwnerReg <= OWN_NONE;
         burstCntReg  <= 8'd0;
         rspSelReg    <= OWN_NONE;
      end else begin
         lastGntReg   <= lastGntNext;
         lockOwnerReg <= lockOwnerNext;
         burstCntReg  <= burstCntNext;
         rspSelReg    <= rspSelNext;
      end
   end

   // ------------------------------------------------------------------------
   // Responses: the RAM output register already provides the one-cycle delay,
   // so data is passed straight through and only the tag is registered here.
   // ------------------------------------------------------------------------
   assign rsp0_valid = (rspSelReg == OWN_REQ0);
   assign rsp1_valid = (rspSelReg == OWN_REQ1);
   assign rsp_rdata  = memBRead;

endmodule

// File: tb/tb_dpram_portb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dpram_portb_arbiter (MAX_BURST = 4).
// Contains a behavioural port-B RAM (registered read, write pass-through) and
// a rule-level reference model of the arbitration and response stream.
// -----------------------------------------------------------------------------
module tb_dpram_portb_arbiter;

   localparam int WS   = 32;
   localparam int MAXA = 15;
   localparam int MINA = 2;
   localparam int MAXB = 4;
   localparam int AW   = MAXA - MINA + 1;

   logic          clk = 1'b0;
   logic          areset_n;
   logic          req0_valid, req0_we, req0_lock;
   logic [AW-1:0] req0_addr;
   logic [WS-1:0] req0_wdata;
   logic          req1_valid, req1_we, req1_lock;
   logic [AW-1:0] req1_addr;
   logic [WS-1:0] req1_wdata;
   logic          gnt0, gnt1, rsp0_valid, rsp1_valid;
   logic [WS-1:0] rsp_rdata;
   logic          memBWriteEnable;
   logic [AW-1:0] memBAddr;
   logic [WS-1:0] memBWrite;
   logic [WS-1:0] memBRead = '0;

   dpram_portb_arbiter #(
      .wordSize(WS), .maxAddrBitBRAM(MAXA), .minAddrBit(MINA), .MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .areset_n(areset_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_lock(req0_lock),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_lock(req1_lock),
      .gnt0(gnt0), .gnt1(gnt1), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_rdata(rsp_rdata),
      .memBWriteEnable(memBWriteEnable), .memBAddr(memBAddr),
      .memBWrite(memBWrite), .memBRead(memBRead)
   );

   always #5 clk = ~clk;

   // Port-B RAM: registered read, write data passed through to the output.
   logic [WS-1:0] ramArr [int];
   always @(posedge clk) begin
      if (memBWriteEnable) begin
         ramArr[int'(memBAddr)] = memBWrite;
         memBRead <= memBWrite;
      end else begin
         memBRead <= ramArr.exists(int'(memBAddr)) ? ramArr[int'(memBAddr)] : '0;
      end
   end

   typedef struct {
      logic          valid;
      logic          we;
      logic [AW-1:0] addr;
      logic [WS-1:0] wdata;
      logic          lock;
   } req_t;

   typedef struct {
      bit rst;
      bit v0;
      bit v1;
      bit l0;
      bit l1;
      int expG;
   } vec_t;

   req_t r0, r1;
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   txnNo  = 0;

   // Reference model state (rule level: who was served, who owns the lock,
   // how long the current run is, who gets a response next cycle).
   int            mLast;
   int            mOwner;
   int            mBurst;
   int            mRspSel;
   logic [WS-1:0] mRspData;
   logic [WS-1:0] modelMem [int];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      req0_valid = r0.valid; req0_we = r0.we; req0_addr = r0.addr;
      req0_wdata = r0.wdata; req0_lock = r0.lock;
      req1_valid = r1.valid; req1_we = r1.we; req1_addr = r1.addr;
      req1_wdata = r1.wdata; req1_lock = r1.lock;
   endtask

   task automatic modelReset();
      mLast = 1; mOwner = -1; mBurst = 0; mRspSel = -1; mRspData = '0;
   endtask

   function automatic logic [WS-1:0] modelRead(input int a);
      return modelMem.exists(a) ? modelMem[a] : '0;
   endfunction

   // Winner of the current cycle according to the arbitration rules.
   function automatic int predict();
      logic ownerValid;
      ownerValid = (mOwner == 0) ? r0.valid : r1.valid;
      if (mOwner >= 0 && ownerValid && mBurst < MAXB) return mOwner;
      if (r0.valid && r1.valid) return 1 - mLast;
      if (r0.valid) return 0;
      if (r1.valid) return 1;
      return -1;
   endfunction

   task automatic modelCommit(input int g);
      req_t rg;
      if (g >= 0) begin
         rg = (g == 1) ? r1 : r0;
         mBurst   = (g == mRspSel) ? ((mBurst + 1 > MAXB) ? MAXB : mBurst + 1) : 1;
         mLast    = g;
         mOwner   = rg.lock ? g : -1;
         mRspSel  = g;
         mRspData = rg.we ? rg.wdata : modelRead(int'(rg.addr));
         if (rg.we) modelMem[int'(rg.addr)] = rg.wdata;
      end else begin
         mBurst  = 0;
         mOwner  = -1;
         mRspSel = -1;
      end
   endtask

   // One clock cycle: drive after the edge, check mid-cycle, advance model.
   task automatic doCycle(output int gExp, output int gObs);
      logic expWe;
      req_t rm;
      @(posedge clk);
      #1;
      areset_n = 1'b1;
      drive();
      #2;
      chk("rsp0_valid", 64'(rsp0_valid), 64'(mRspSel == 0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(mRspSel == 1));
      if (mRspSel >= 0) chk("rsp_rdata", 64'(rsp_rdata), 64'(mRspData));
      gExp  = predict();
      gObs  = gnt0 ? (gnt1 ? 2 : 0) : (gnt1 ? 1 : -1);
      chk("gnt", 64'(gObs), 64'(gExp));
      rm    = (gExp == 1) ? r1 : r0;
      expWe = (gExp >= 0) ? rm.we : 1'b0;
      chk("memBWriteEnable", 64'(memBWriteEnable), 64'(expWe));
      chk("memBAddr", 64'(memBAddr), 64'(rm.addr));
      chk("memBWrite", 64'(memBWrite), 64'(rm.wdata));
      txnNo++;
      $display("txn %0d gnt=%0d we=%0b addr=%0h wdata=%h rsp0=%0b rsp1=%0b rdata=%h",
               txnNo, gObs, memBWriteEnable, memBAddr, memBWrite, rsp0_valid, rsp1_valid, rsp_rdata);
      modelCommit(gExp);
   endtask

   task automatic checkResetOutputs();
      chk("rst_gnt0", 64'(gnt0), 64'(0));
      chk("rst_gnt1", 64'(gnt1), 64'(0));
      chk("rst_we", 64'(memBWriteEnable), 64'(0));
      chk("rst_rsp0", 64'(rsp0_valid), 64'(0));
      chk("rst_rsp1", 64'(rsp1_valid), 64'(0));
   endtask

   // Assert reset just after an edge and keep it for holdCycles more edges.
   task automatic applyReset(input int holdCycles);
      @(posedge clk);
      #1;
      areset_n = 1'b0;
      drive();
      modelReset();
      #2;
      checkResetOutputs();
      for (int k = 0; k < holdCycles; k++) begin
         @(posedge clk);
         #3;
         checkResetOutputs();
      end
   endtask

   task automatic addVec(input bit rst, input bit v0, input bit v1,
                         input bit l0, input bit l1, input int expG);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.v1 = v1; v.l0 = l0; v.l1 = l1; v.expG = expG;
      tbl.push_back(v);
   endtask

   initial begin
      int ge;
      int go;
      r0 = '{valid: 1'b0, we: 1'b0, addr: '0, wdata: '0, lock: 1'b0};
      r1 = r0;
      areset_n = 1'b0;
      drive();
      modelReset();
      ramArr[16]   = 32'hDEADBEEF;
      modelMem[16] = 32'hDEADBEEF;

      // Reset with both requesters writing to address 5.
      r0 = '{valid: 1'b1, we: 1'b1, addr: 14'd5, wdata: 32'hAAAA0000, lock: 1'b0};
      r1 = '{valid: 1'b1, we: 1'b1, addr: 14'd5, wdata: 32'hBBBB0000, lock: 1'b0};
      applyReset(3);
      doCycle(ge, go);
      chk("rst_first_gnt", 64'(go), 64'(0));
      r0.valid = 1'b0;
      doCycle(ge, go);
      r1.valid = 1'b0;
      doCycle(ge, go);

      // Single read by requester 1.
      r1 = '{valid: 1'b1, we: 1'b0, addr: 14'h10, wdata: '0, lock: 1'b0};
      doCycle(ge, go);
      chk("read_gnt1", 64'(go), 64'(1));
      r1.valid = 1'b0;
      doCycle(ge, go);
      chk("read_rsp1", 64'(rsp1_valid), 64'(1));
      chk("read_rsp0", 64'(rsp0_valid), 64'(0));
      chk("read_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));

      // Write then read back by requester 0.
      r0 = '{valid: 1'b1, we: 1'b1, addr: 14'd3, wdata: 32'h12345678, lock: 1'b0};
      doCycle(ge, go);
      r0.we = 1'b0;
      r0.wdata = '0;
      doCycle(ge, go);
      chk("wr_rsp0", 64'(rsp0_valid), 64'(1));
      r0.valid = 1'b0;
      doCycle(ge, go);
      chk("rd_rsp0", 64'(rsp0_valid), 64'(1));
      chk("wr_rd_rdata", 64'(rsp_rdata), 64'(32'h12345678));

      // Arbitration vectors: {reset first, v0, v1, lock0, lock1, expected grant}.
      addVec(1, 1, 1, 0, 0, 0);                       // round robin
      addVec(0, 1, 1, 0, 0, 1); addVec(0, 1, 1, 0, 0, 0);
      addVec(0, 1, 1, 0, 0, 1); addVec(0, 1, 1, 0, 0, 0);
      addVec(0, 1, 1, 0, 0, 1);
      addVec(1, 1, 1, 0, 1, 0);                       // burst lock by requester 1
      addVec(0, 1, 1, 0, 1, 1); addVec(0, 1, 1, 0, 1, 1);
      addVec(0, 1, 1, 0, 1, 1); addVec(0, 1, 1, 0, 1, 1);
      addVec(0, 1, 1, 0, 1, 0); addVec(0, 1, 1, 0, 1, 1);
      addVec(0, 1, 1, 0, 1, 1); addVec(0, 1, 1, 0, 1, 1);
      addVec(0, 1, 1, 0, 1, 1);
      addVec(1, 0, 1, 0, 1, 1);                       // lone locked owner saturates
      for (int k = 0; k < 6; k++) addVec(0, 0, 1, 0, 1, 1);
      addVec(0, 1, 1, 0, 1, 0);                       // expired lock yields
      addVec(0, 0, 1, 0, 1, 1);
      addVec(0, 1, 0, 0, 0, 0);                       // owner drops valid
      addVec(0, 0, 0, 0, 0, -1);                      // idle
      addVec(0, 1, 1, 0, 0, 1);
      addVec(0, 1, 1, 1, 0, 0);                       // requester 0 locks
      addVec(0, 1, 1, 1, 0, 0);
      addVec(0, 1, 1, 0, 0, 0);
      addVec(0, 1, 1, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         r0 = '{valid: tbl[i].v0, we: 1'b0, addr: 14'h20, wdata: '0, lock: tbl[i].l0};
         r1 = '{valid: tbl[i].v1, we: 1'b0, addr: 14'h21, wdata: '0, lock: tbl[i].l1};
         if (tbl[i].rst) applyReset(1);
         doCycle(ge, go);
         chk($sformatf("tbl_gnt[%0d]", i), 64'(go), 64'(tbl[i].expG));
      end
      r0.valid = 1'b0;
      r1.valid = 1'b0;

      // Randomised traffic; requests stay put until granted.
      for (int n = 0; n < 400; n++) begin
         if (!r0.valid && $urandom_range(0, 3) != 0) begin
            r0.valid = 1'b1;
            r0.we    = 1'($urandom_range(0, 1));
            r0.addr  = AW'($urandom_range(0, 15));
            r0.wdata = $urandom;
         end
         if (!r1.valid && $urandom_range(0, 3) != 0) begin
            r1.valid = 1'b1;
            r1.we    = 1'($urandom_range(0, 1));
            r1.addr  = AW'($urandom_range(0, 15));
            r1.wdata = $urandom;
         end
         r0.lock = ($urandom_range(0, 2) == 0);
         r1.lock = 1'($urandom_range(0, 1));
         doCycle(ge, go);
         if (ge == 0) r0.valid = 1'b0;
         if (ge == 1) r1.valid = 1'b0;
      end

      // Reset right after a requester-1 grant drops its response.
      r0.valid = 1'b0;
      doCycle(ge, go);
      r1 = '{valid: 1'b1, we: 1'b0, addr: 14'h10, wdata: '0, lock: 1'b0};
      doCycle(ge, go);
      chk("midrst_gnt1", 64'(go), 64'(1));
      r1.valid = 1'b0;
      applyReset(2);
      chk("midrst_rsp1_drop", 64'(rsp1_valid), 64'(0));
      doCycle(ge, go);
      chk("midrst_no_rsp1", 64'(rsp1_valid), 64'(0));
      doCycle(ge, go);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
